// File: rtl/sad_search_ctrl.sv
// rtl/sad_search_ctrl.sv - raster-order motion-vector sequencer for the SAD compare stage
module sad_search_ctrl #(
    parameter int SR       = 16,
    parameter int PIPE_LAT = 4,
    parameter int MVW      = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           stall_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           comp_clear_o,
    output logic           cand_valid_o,
    output logic [MVW-1:0] cand_mvx_o,
    output logic [MVW-1:0] cand_mvy_o,
    output logic           comp_en_o,
    output logic [MVW-1:0] comp_mvx_o,
    output logic [MVW-1:0] comp_mvy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [MVW-1:0] MV_MIN = MVW'(-SR);
    localparam logic [MVW-1:0] MV_MAX = MVW'(SR - 1);
    localparam int             CW     = $clog2(PIPE_LAT + 1);

    state_t         state_q, state_d;
    logic [MVW-1:0] mvx_q, mvx_d;
    logic [MVW-1:0] mvy_q, mvy_d;
    logic [CW-1:0]  drain_q, drain_d;

    logic [PIPE_LAT-1:0] dv_q;
    logic [MVW-1:0]      dx_q [PIPE_LAT];
    logic [MVW-1:0]      dy_q [PIPE_LAT];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mvx_q   <= '0;
            mvy_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            mvx_q   <= mvx_d;
            mvy_q   <= mvy_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mvx_d        = mvx_q;
        mvy_d        = mvy_q;
        drain_d      = drain_q;
        busy_o       = (state_q != S_IDLE);
        done_o       = 1'b0;
        comp_clear_o = 1'b0;
        cand_valid_o = 1'b0;
        cand_mvx_o   = '0;
        cand_mvy_o   = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                comp_clear_o = 1'b1;
                mvx_d        = MV_MIN;
                mvy_d        = MV_MIN;
                state_d      = S_SCAN;
            end
            S_SCAN: begin
                // MV stays visible while stalled so the fetch side can hold its request
                cand_valid_o = !stall_i;
                cand_mvx_o   = mvx_q;
                cand_mvy_o   = mvy_q;
                if (!stall_i) begin
                    if (mvx_q == MV_MAX) begin
                        mvx_d = MV_MIN;
                        if (mvy_q == MV_MAX) begin
                            state_d = S_DRAIN;
                            drain_d = CW'(PIPE_LAT - 1);
                        end else begin
                            mvy_d = mvy_q + MVW'(1);
                        end
                    end else begin
                        mvx_d = mvx_q + MVW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_DONE;
                else               drain_d = drain_q - CW'(1);
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shifts every cycle, so stalls propagate as comp_en bubbles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dv_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dx_q[i] <= '0;
                dy_q[i] <= '0;
            end
        end else begin
            dv_q[0] <= cand_valid_o;
            dx_q[0] <= cand_valid_o ? cand_mvx_o : '0;
            dy_q[0] <= cand_valid_o ? cand_mvy_o : '0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dv_q[i] <= dv_q[i-1];
                dx_q[i] <= dx_q[i-1];
                dy_q[i] <= dy_q[i-1];
            end
        end
    end

    assign comp_en_o  = dv_q[PIPE_LAT-1];
    assign comp_mvx_o = dx_q[PIPE_LAT-1];
    assign comp_mvy_o = dy_q[PIPE_LAT-1];

endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb/tb_sad_search_ctrl.sv - scoreboard bench for sad_search_ctrl with a SAD_comp model
module tb_sad_search_ctrl;

    localparam int SR  = 2;
    localparam int PL  = 4;
    localparam int MVW = 2;
    localparam int N   = (2 * SR) * (2 * SR);
    localparam int BIG = 1 << 30;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           stall = 1'b0;
    logic           busy, done, comp_clear, cand_valid, comp_en;
    logic [MVW-1:0] cand_mvx, cand_mvy, comp_mvx, comp_mvy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int c;
        int x;
        int y;
    } ev_t;

    ev_t cand_q[$];
    ev_t comp_q[$];
    ev_t done_q[$];
    int  clear_q[$];

    int          busy_from = BIG;
    int          busy_to   = BIG;
    int unsigned sad[N];
    int unsigned cur_min;
    int          cap_x, cap_y;
    int          ncomp      = 0;
    int          comp_total = 0;
    bit          hold_chk   = 1'b0;
    int          hold_x, hold_y;

    sad_search_ctrl #(.SR(SR), .PIPE_LAT(PL), .MVW(MVW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stall_i     (stall),
        .busy_o      (busy),
        .done_o      (done),
        .comp_clear_o(comp_clear),
        .cand_valid_o(cand_valid),
        .cand_mvx_o  (cand_mvx),
        .cand_mvy_o  (cand_mvy),
        .comp_en_o   (comp_en),
        .comp_mvx_o  (comp_mvx),
        .comp_mvy_o  (comp_mvy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int mv_x(input int k);
        return (k % (2 * SR)) - SR;
    endfunction

    function automatic int mv_y(input int k);
        return (k / (2 * SR)) - SR;
    endfunction

    function automatic int all_outs();
        logic [12:0] v;
        v = {busy, done, comp_clear, cand_valid, comp_en, cand_mvx, cand_mvy, comp_mvx, comp_mvy};
        return int'(v);
    endfunction

    // Monitor: pops expectations whenever the DUT presents an event
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", int'(busy), int'(cyc >= busy_from && cyc <= busy_to));
            if (hold_chk) begin
                chk("stall_hold_x", int'($signed(cand_mvx)), hold_x);
                chk("stall_hold_y", int'($signed(cand_mvy)), hold_y);
                chk("stall_no_valid", int'(cand_valid), 0);
            end
            if (comp_clear) begin
                chk("clear_with_comp_en", int'(comp_en), 0);
                if (clear_q.size() == 0) chk("clear_unexpected", 1, 0);
                else chk("clear_cycle", cyc, clear_q.pop_front());
                cur_min = 32'hFFFF_FFFF;
                ncomp   = 0;
            end
            if (cand_valid) begin
                if (cand_q.size() == 0) chk("cand_unexpected", 1, 0);
                else begin
                    ev_t e;
                    e = cand_q.pop_front();
                    chk("cand_cycle", cyc, e.c);
                    chk("cand_x", int'($signed(cand_mvx)), e.x);
                    chk("cand_y", int'($signed(cand_mvy)), e.y);
                end
            end
            if (comp_en) begin
                comp_total++;
                if (comp_q.size() == 0) chk("comp_unexpected", 1, 0);
                else begin
                    ev_t e;
                    int  ix, iy;
                    e  = comp_q.pop_front();
                    ix = int'($signed(comp_mvx));
                    iy = int'($signed(comp_mvy));
                    chk("comp_cycle", cyc, e.c);
                    chk("comp_x", ix, e.x);
                    chk("comp_y", iy, e.y);
                    ncomp++;
                    if (sad[(iy + SR) * 2 * SR + (ix + SR)] < cur_min) begin
                        cur_min = sad[(iy + SR) * 2 * SR + (ix + SR)];
                        cap_x   = ix;
                        cap_y   = iy;
                    end
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    ev_t e;
                    e = done_q.pop_front();
                    chk("done_cycle", cyc, e.c);
                    chk("comp_count", ncomp, N);
                    chk("best_x", cap_x, e.x);
                    chk("best_y", cap_y, e.y);
                end
            end
        end
    end

    task automatic reset_abort();
        int snap;
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        hold_chk = 1'b0;
        #1;
        chk("rst_midscan_outputs", all_outs(), 0);
        cand_q.delete();
        comp_q.delete();
        done_q.delete();
        clear_q.delete();
        busy_from = BIG;
        busy_to   = BIG;
        step();
        step();
        rst = 1'b0;
        snap = comp_total;
        repeat (10) step();
        chk("post_rst_comp_en", comp_total - snap, 0);
        chk("post_rst_outputs", all_outs(), 0);
    endtask

    // mode 0: no stall, 1: stall at relative cycles 5..7, 2: random stall
    task automatic run_search(input int mode, input int min_idx, input bit extra, input int abort_at);
        int s, k, rel, done_c;
        for (int i = 0; i < N; i++) sad[i] = $urandom_range(1, 1000);
        sad[min_idx] = 0;
        s = cyc;
        start = 1'b1;
        clear_q.push_back(s + 1);
        busy_from = s + 1;
        busy_to   = BIG;
        step();
        start = 1'b0;
        step();
        k = 0;
        done_c = BIG;
        while (k < N) begin
            rel = cyc - s;
            case (mode)
                0:       stall = 1'b0;
                1:       stall = (rel >= 5 && rel <= 7);
                default: stall = ($urandom_range(0, 3) == 0);
            endcase
            start = extra && (k == 3);
            if (abort_at >= 0 && k == abort_at && !stall) begin
                reset_abort();
                return;
            end
            hold_chk = stall;
            hold_x   = mv_x(k);
            hold_y   = mv_y(k);
            if (!stall) begin
                cand_q.push_back('{cyc, mv_x(k), mv_y(k)});
                comp_q.push_back('{cyc + PL, mv_x(k), mv_y(k)});
                k++;
                if (k == N) begin
                    done_c = cyc + 1 + PL;
                    done_q.push_back('{done_c, mv_x(min_idx), mv_y(min_idx)});
                    busy_to = done_c;
                end
            end
            step();
        end
        stall = 1'b0;
        start = 1'b0;
        hold_chk = 1'b0;
        while (cyc < done_c) step();
        start = extra;
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        step();
        chk("idle_outputs", all_outs(), 0);
        run_search(0, $urandom_range(0, N - 1), 1'b0, -1);
        run_search(1, 14, 1'b0, -1);
        run_search(0, 14, 1'b1, -1);
        run_search(0, $urandom_range(0, N - 1), 1'b0, -1);
        run_search(0, $urandom_range(0, N - 1), 1'b0, 5);
        repeat (3) run_search(2, $urandom_range(0, N - 1), 1'b0, -1);
        repeat (PL + 3) step();
        chk("queues_empty", cand_q.size() + comp_q.size() + done_q.size() + clear_q.size(), 0);
        chk("final_idle", all_outs(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
